// File: rtl/lock_seq_ctrl.sv
// Serial combination-lock controller: collects code bits, checks them against the stored
// code, drives a timed unlock window and an alarm lockout. Optional feature macro: PROG_CODE_EN.
module lock_seq_ctrl #(
  parameter int                  CODE_LEN    = 4,
  parameter logic [CODE_LEN-1:0] CODE        = 4'b1011,
  parameter int                  UNLOCK_CYC  = 8,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCKOUT_CYC = 16
) (
  input  logic                             clk,
  input  logic                             clr,
  input  logic                             in_data,
  input  logic                             in_en,
  input  logic                             in_prog,
  output logic                             out_unlock,
  output logic                             out_err,
  output logic                             out_alarm,
  output logic                             out_busy,
  output logic [$clog2(CODE_LEN+1)-1:0]    out_cnt
);

  localparam int CNT_W   = $clog2(CODE_LEN + 1);
  localparam int TMR_MAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_TRIES + 1);

  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CODE_LEN - 1);
  localparam logic [FAIL_W-1:0] LAST_TRY = FAIL_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [CODE_LEN-1:0] r_shift;
  logic [CODE_LEN-1:0] w_shiftNext;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cntNext;
  logic [FAIL_W-1:0]   r_failCnt;
  logic [FAIL_W-1:0]   w_failNext;
  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timerNext;
  logic                w_errEvent;

  logic                r_unlock;
  logic                r_err;
  logic                r_alarm;
  logic                r_busy;
  logic                w_unlockNext;
  logic                w_errNext;
  logic                w_alarmNext;
  logic                w_busyNext;

  logic [CODE_LEN-1:0] w_storedCode;
  logic                w_holdOpen;

`ifdef PROG_CODE_EN
  // Programming mode reuses the OPEN state; the armed flag freezes the unlock timer.
  logic [CODE_LEN-1:0] r_code;
  logic [CODE_LEN-1:0] w_codeNext;
  logic                r_progArmed;
  logic                w_progNext;

  assign w_storedCode = r_code;
  assign w_holdOpen   = r_progArmed | in_prog;
`else
  logic                w_unusedProg;

  assign w_unusedProg = in_prog;
  assign w_storedCode = CODE;
  assign w_holdOpen   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_failCnt <= '0;
      r_timer   <= '0;
      r_unlock  <= 1'b0;
      r_err     <= 1'b0;
      r_alarm   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_shift   <= w_shiftNext;
      r_cnt     <= w_cntNext;
      r_failCnt <= w_failNext;
      r_timer   <= w_timerNext;
      r_unlock  <= w_unlockNext;
      r_err     <= w_errNext;
      r_alarm   <= w_alarmNext;
      r_busy    <= w_busyNext;
    end
  end

`ifdef PROG_CODE_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      r_code      <= CODE;
      r_progArmed <= 1'b0;
    end else begin
      r_code      <= w_codeNext;
      r_progArmed <= w_progNext;
    end
  end
`endif

  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_cntNext   = r_cnt;
    w_failNext  = r_failCnt;
    w_timerNext = r_timer;
    w_errEvent  = 1'b0;
`ifdef PROG_CODE_EN
    w_codeNext  = r_code;
    w_progNext  = r_progArmed;
`endif
    case (r_state)
      IDLE, ENTRY: begin
        if (in_en) begin
          w_shiftNext = {r_shift[CODE_LEN-2:0], in_data};
          w_cntNext   = r_cnt + 1'b1;
          w_stateNext = (r_cnt == LAST_BIT) ? CHECK : ENTRY;
        end
      end
      CHECK: begin
        w_cntNext   = '0;
        w_shiftNext = '0;
        if (r_shift == w_storedCode) begin
          w_stateNext = OPEN;
          w_failNext  = '0;
          w_timerNext = TMR_W'(UNLOCK_CYC);
        end else if (r_failCnt == LAST_TRY) begin
          w_stateNext = LOCKOUT;
          w_failNext  = '0;
          w_timerNext = TMR_W'(LOCKOUT_CYC);
        end else begin
          w_stateNext = IDLE;
          w_failNext  = r_failCnt + 1'b1;
          w_errEvent  = 1'b1;
        end
      end
      OPEN: begin
        if (!w_holdOpen) begin
          if (r_timer != '0) w_timerNext = r_timer - 1'b1;
          if (r_timer <= TMR_ONE) w_stateNext = IDLE;
        end
`ifdef PROG_CODE_EN
        if (r_progArmed) begin
          if (in_en) begin
            w_codeNext = {r_code[CODE_LEN-2:0], in_data};
            w_cntNext  = r_cnt + 1'b1;
            if (r_cnt == LAST_BIT) begin
              w_stateNext = IDLE;
              w_cntNext   = '0;
              w_timerNext = '0;
              w_progNext  = 1'b0;
            end
          end
        end else if (in_prog) begin
          w_progNext = 1'b1;
        end
`endif
      end
      LOCKOUT: begin
        if (r_timer != '0) w_timerNext = r_timer - 1'b1;
        if (r_timer <= TMR_ONE) w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
        w_shiftNext = '0;
        w_timerNext = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track the state register.
  always_comb begin
    w_unlockNext = (w_stateNext == OPEN);
    w_alarmNext  = (w_stateNext == LOCKOUT);
    w_busyNext   = (w_stateNext == CHECK) || (w_stateNext == OPEN) || (w_stateNext == LOCKOUT);
    w_errNext    = w_errEvent;
  end

  assign out_unlock = r_unlock;
  assign out_err    = r_err;
  assign out_alarm  = r_alarm;
  assign out_busy   = r_busy;
  assign out_cnt    = r_cnt;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Self-checking bench for lock_seq_ctrl: directed vector table, hand-written corner
// sequences and a randomized phase against a schedule-based reference model.
module tb_lock_seq_ctrl;

  localparam int CODE_LEN    = 4;
  localparam int UNLOCK_CYC  = 8;
  localparam int MAX_TRIES   = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int N_RAND      = 1500;
  localparam int HORIZON     = N_RAND + 64;

`ifdef PROG_CODE_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       inData = 1'b0;
  logic       inEn = 1'b0;
  logic       inProg = 1'b0;
  logic       outUnlock;
  logic       outErr;
  logic       outAlarm;
  logic       outBusy;
  logic [2:0] outCnt;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  logic [3:0] codeVal = 4'b1011;

  typedef struct {
    logic clr, en, data;
    logic unlock, err, alarm, busy;
    logic [2:0] cnt;
  } vec_t;
  vec_t vecs[$];

  // Reference model: outcomes are scheduled forward in time from the completing entry.
  bit   mUnlock[HORIZON];
  bit   mErr[HORIZON];
  bit   mAlarm[HORIZON];
  bit   mBusy[HORIZON];
  int   mCnt[HORIZON];
  int   mBits[$];
  int   mFails = 0;
  int   mFreeAt = 0;

  lock_seq_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE(4'b1011), .UNLOCK_CYC(UNLOCK_CYC),
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .clr(clr), .in_data(inData), .in_en(inEn), .in_prog(inProg),
    .out_unlock(outUnlock), .out_err(outErr), .out_alarm(outAlarm),
    .out_busy(outBusy), .out_cnt(outCnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic c, input logic e, input logic d, input logic p);
    clr = c; inEn = e; inData = d; inProg = p;
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic checkOutput(input string name, input logic u, input logic e, input logic a,
                             input logic b, input logic [2:0] c);
    logic [6:0] act;
    logic [6:0] exp;
    act = {outUnlock, outErr, outAlarm, outBusy, outCnt};
    exp = {u, e, a, b, c};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got unlock/err/alarm/busy=%b%b%b%b cnt=%0d, want %b%b%b%b cnt=%0d",
               name, cycleNo, act[6], act[5], act[4], act[3], act[2:0], u, e, a, b, c);
    end
  endtask

  task automatic addRow(input logic c, input logic e, input logic d, input logic u,
                        input logic er, input logic a, input logic b, input logic [2:0] n);
    vec_t v;
    v.clr = c; v.en = e; v.data = d; v.unlock = u; v.err = er; v.alarm = a; v.busy = b; v.cnt = n;
    vecs.push_back(v);
  endtask

  task automatic enterCode(input logic [3:0] code, input string name);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, code[3-i], 1'b0);
      checkOutput(name, 1'b0, 1'b0, 1'b0, (i == 3), 3'(i + 1));
    end
  endtask

  task automatic modelStep(input int n, input logic c, input logic e, input logic d);
    int value;
    if (c) begin
      for (int i = n; i < HORIZON; i++) begin
        mUnlock[i] = 0; mErr[i] = 0; mAlarm[i] = 0; mBusy[i] = 0; mCnt[i] = 0;
      end
      mBits.delete();
      mFails = 0;
      mFreeAt = n + 1;
      return;
    end
    if (e && n >= mFreeAt) begin
      mBits.push_back(int'(d));
      if (mBits.size() == CODE_LEN) begin
        value = 0;
        foreach (mBits[i]) value = value * 2 + mBits[i];
        mCnt[n] = CODE_LEN;
        mBusy[n] = 1;
        if (value == int'(codeVal)) begin
          for (int i = 1; i <= UNLOCK_CYC; i++) begin mUnlock[n+i] = 1; mBusy[n+i] = 1; end
          mFails = 0;
          mFreeAt = n + UNLOCK_CYC + 2;
        end else if (mFails + 1 < MAX_TRIES) begin
          mErr[n+1] = 1;
          mFails++;
          mFreeAt = n + 2;
        end else begin
          for (int i = 1; i <= LOCKOUT_CYC; i++) begin mAlarm[n+i] = 1; mBusy[n+i] = 1; end
          mFails = 0;
          mFreeAt = n + LOCKOUT_CYC + 2;
        end
        mBits.delete();
        return;
      end
    end
    mCnt[n] = mBits.size();
  endtask

  initial begin
    logic rClr, rEn, rData;
    int pos;

    // Reset, correct code, single wrong then correct, two wrong without alarm
    addRow(1,0,0, 0,0,0,0,0);
    addRow(1,1,1, 0,0,0,0,0);
    addRow(0,1,1, 0,0,0,0,1);
    addRow(0,1,0, 0,0,0,0,2);
    addRow(0,1,1, 0,0,0,0,3);
    addRow(0,1,1, 0,0,0,1,4);
    addRow(0,1,0, 1,0,0,1,0);
    for (int i = 0; i < 7; i++) addRow(0,1,i[0], 1,0,0,1,0);
    addRow(0,0,0, 0,0,0,0,0);
    addRow(0,1,1, 0,0,0,0,1);
    addRow(0,1,1, 0,0,0,0,2);
    addRow(0,1,1, 0,0,0,0,3);
    addRow(0,1,1, 0,0,0,1,4);
    addRow(0,1,0, 0,1,0,0,0);
    addRow(0,0,0, 0,0,0,0,0);
    addRow(0,1,1, 0,0,0,0,1);
    addRow(0,1,0, 0,0,0,0,2);
    addRow(0,1,1, 0,0,0,0,3);
    addRow(0,1,1, 0,0,0,1,4);
    for (int i = 0; i < 8; i++) addRow(0,0,0, 1,0,0,1,0);
    addRow(0,0,0, 0,0,0,0,0);
    addRow(0,1,1, 0,0,0,0,1);
    addRow(0,0,0, 0,0,0,0,1);
    addRow(0,1,1, 0,0,0,0,2);
    addRow(0,1,1, 0,0,0,0,3);
    addRow(0,1,1, 0,0,0,1,4);
    addRow(0,0,0, 0,1,0,0,0);
    addRow(0,1,0, 0,0,0,0,1);
    addRow(0,1,0, 0,0,0,0,2);
    addRow(0,1,0, 0,0,0,0,3);
    addRow(0,1,0, 0,0,0,1,4);
    addRow(0,0,0, 0,1,0,0,0);
    addRow(0,0,0, 0,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].clr, vecs[i].en, vecs[i].data, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].unlock, vecs[i].err, vecs[i].alarm,
                  vecs[i].busy, vecs[i].cnt);
    end

    // Lockout after three wrong entries; bits during lockout are discarded
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkOutput("lockRst", 0,0,0,0,0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0); checkOutput("lockRst", 0,0,0,0,0);
    enterCode(4'b1111, "lockW1"); applyStimulus(0,0,0,0); checkOutput("lockErr1", 0,1,0,0,0);
    enterCode(4'b1111, "lockW2"); applyStimulus(0,0,0,0); checkOutput("lockErr2", 0,1,0,0,0);
    enterCode(4'b0000, "lockW3"); applyStimulus(0,0,0,0); checkOutput("lockAlarm", 0,0,1,1,0);
    for (int i = 1; i < LOCKOUT_CYC; i++) begin
      applyStimulus(1'b0, i[0], 1'b1, 1'b0);
      checkOutput("lockHold", 0,0,1,1,0);
    end
    applyStimulus(0,0,0,0); checkOutput("lockExit", 0,0,0,0,0);
    enterCode(4'b1011, "lockOk");
    for (int i = 0; i < UNLOCK_CYC; i++) begin
      applyStimulus(0,0,0,0); checkOutput("lockOkOpen", 1,0,0,1,0);
    end
    applyStimulus(0,0,0,0); checkOutput("lockOkClose", 0,0,0,0,0);

    // Reset mid-entry also clears the failure count
    enterCode(4'b0101, "rstW1"); applyStimulus(0,0,0,0); checkOutput("rstErr1", 0,1,0,0,0);
    enterCode(4'b0001, "rstW2"); applyStimulus(0,0,0,0); checkOutput("rstErr2", 0,1,0,0,0);
    applyStimulus(0,1,1,0); checkOutput("rstBit1", 0,0,0,0,1);
    applyStimulus(0,1,0,0); checkOutput("rstBit2", 0,0,0,0,2);
    applyStimulus(1,0,0,0); checkOutput("rstMidEntry", 0,0,0,0,0);
    enterCode(4'b1110, "rstW3"); applyStimulus(0,0,0,0); checkOutput("rstNoAlarm", 0,1,0,0,0);
    // Reset in OPEN cycle 3 and in LOCKOUT cycle 5
    enterCode(4'b1011, "rstOpen");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0,0); checkOutput("rstOpenHi", 1,0,0,1,0);
    end
    applyStimulus(1,0,0,0); checkOutput("rstInOpen", 0,0,0,0,0);
    applyStimulus(0,0,0,0); checkOutput("rstIdle", 0,0,0,0,0);
    enterCode(4'b0000, "rstL1"); applyStimulus(0,0,0,0); checkOutput("rstLErr1", 0,1,0,0,0);
    enterCode(4'b0000, "rstL2"); applyStimulus(0,0,0,0); checkOutput("rstLErr2", 0,1,0,0,0);
    enterCode(4'b0000, "rstL3");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0,0,0,0); checkOutput("rstLAlarm", 0,0,1,1,0);
    end
    applyStimulus(1,0,0,0); checkOutput("rstInLock", 0,0,0,0,0);
    applyStimulus(0,0,0,0); checkOutput("rstIdle2", 0,0,0,0,0);

    // Code programming from OPEN (or ignored when the feature is absent)
    enterCode(4'b1011, "progOpen");
    applyStimulus(0,0,0,0); checkOutput("progOpen1", 1,0,0,1,0);
    applyStimulus(0,0,0,1); checkOutput("progArm", 1,0,0,1,0);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] newCode;
      newCode = 4'b0110;
      applyStimulus(1'b0, 1'b1, newCode[3-i], 1'b0);
      checkOutput("progBit", PROG ? (i < 3) : 1'b1, 0, 0, PROG ? (i < 3) : 1'b1,
                  PROG ? ((i == 3) ? 3'd0 : 3'(i + 1)) : 3'd0);
    end
    for (int j = 0; j < 3; j++) begin
      applyStimulus(0,0,0,0);
      checkOutput("progDrain", !PROG && (j < 2), 0, 0, !PROG && (j < 2), 0);
    end
    enterCode(4'b1011, "progOld"); applyStimulus(0,0,0,0);
    checkOutput("progOldRes", !PROG, PROG, 0, !PROG, 0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(0,0,0,0);
      checkOutput("progOldDrain", !PROG && (j < 7), 0, 0, !PROG && (j < 7), 0);
    end
    enterCode(4'b0110, "progNew"); applyStimulus(0,0,0,0);
    checkOutput("progNewRes", PROG, !PROG, 0, PROG, 0);

    // Randomized phase against the reference model; the leading reset restores the default code
    for (int n = 0; n < N_RAND; n++) begin
      rClr = (n < 2) || ($urandom_range(0, 199) == 0);
      rEn = ($urandom_range(0, 3) != 0);
      pos = mBits.size();
      rData = ($urandom_range(0, 2) != 0) ? codeVal[CODE_LEN-1-pos] : 1'($urandom_range(0, 1));
      modelStep(n, rClr, rEn, rData);
      applyStimulus(rClr, rEn, rData, 1'b0);
      checkOutput("rand", mUnlock[n], mErr[n], mAlarm[n], mBusy[n], 3'(mCnt[n]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
